// File: rtl/cache_ram_burst_bridge_pkg.sv
// Shared types and elaboration helpers for the cache/RAM burst bridge.
//   bridge_state_t : transaction FSM states
//   beats()        : RAM beats needed to move one cache block
//   idx_width()    : beat index width, never narrower than one bit
package cache_ram_burst_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    function automatic int beats(input int blocks, input int ram_words);
        return blocks / ram_words;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_ram_burst_bridge_beat_sequencer.sv
// Beat sequencer: walks BEATS beat slots starting at a loadable index,
// wrapping from BEATS-1 back to 0, and flags the final beat of the walk.
//   clock, reset : clock and synchronous active-high reset
//   load         : start a new walk at start_idx
//   start_idx    : first beat slot of the walk
//   advance      : current beat accepted, step to the next slot
//   idx          : current beat slot
//   last         : current beat is the final one of the walk
module beat_sequencer
    import cache_ram_burst_bridge_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int IW    = idx_width(BEATS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [IW-1:0] start_idx,
    input  logic          advance,
    output logic [IW-1:0] idx,
    output logic          last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (load) begin
            idx_d = start_idx;
            cnt_d = '0;
        end else if (advance) begin
            // explicit wrap keeps the slot order correct for critical-word-first
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            cnt_d = cnt_q + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign idx  = idx_q;
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/cache_ram_burst_bridge.sv
// Cache/RAM burst bridge: moves whole cache blocks between the L1 miss port
// and a narrower beat-wide RAM, with optional writeback before refill and
// optional critical-word-first refill order.
//   clock, reset      : clock and synchronous active-high reset
//   mem_req/mem_we    : block transaction request, writeback-first flag
//   mem_addr          : refill byte address; mem_wb_addr : victim byte address
//   mem_write_block   : victim block (word 0 in LSBs)
//   mem_read_block    : refilled block (word 0 in LSBs)
//   mem_miss          : transaction still in progress
//   ram_req/ram_we    : beat request and direction
//   ram_addr          : beat byte address; ram_write_data/ram_read_data : beat data
//   ram_miss          : RAM stall, beat accepted when ram_req && !ram_miss
//   wb_count/fill_count/stall_count : completed writebacks, refills, stall cycles
//
// state | meaning
// IDLE  | waiting for mem_req, latches both block bases on request
// WB    | writing victim beats 0..BEATS-1 to RAM
// FILL  | reading refill beats from the start slot, wrapping
// DONE  | one cycle with mem_miss low, result stable
module cache_ram_burst_bridge
    import cache_ram_burst_bridge_pkg::*;
#(
    parameter int BLOCKS    = 4,
    parameter int RAM_WORDS = 1,
    parameter int CWF       = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req,
    input  logic                     mem_we,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wb_addr,
    input  logic [BLOCKS*32-1:0]     mem_write_block,
    output logic [BLOCKS*32-1:0]     mem_read_block,
    output logic                     mem_miss,
    output logic                     ram_req,
    output logic                     ram_we,
    output logic [31:0]              ram_addr,
    output logic [RAM_WORDS*32-1:0]  ram_write_data,
    input  logic [RAM_WORDS*32-1:0]  ram_read_data,
    input  logic                     ram_miss,
    output logic [31:0]              wb_count,
    output logic [31:0]              fill_count,
    output logic [31:0]              stall_count
);

    localparam int BEATS     = beats(BLOCKS, RAM_WORDS);
    localparam int IW        = idx_width(BEATS);
    localparam int BEAT_BITS = RAM_WORDS * 32;
    localparam int BEAT_SH   = $clog2(RAM_WORDS * 4);
    localparam logic [31:0] BLOCK_MASK = 32'(BLOCKS * 4 - 1);

    if ((BLOCKS % RAM_WORDS) != 0) begin : g_cfg_check
        $error("cache_ram_burst_bridge: RAM_WORDS must divide BLOCKS");
    end

    bridge_state_t          state_q, state_d;
    logic [31:0]            wb_base_q, wb_base_d;
    logic [31:0]            fill_base_q, fill_base_d;
    logic [IW-1:0]          fill_start_q, fill_start_d;
    logic [31:0]            addr_hold_q, addr_hold_d;
    logic [BEAT_BITS-1:0]   wdata_hold_q, wdata_hold_d;
    logic [BLOCKS*32-1:0]   rblock_q, rblock_d;
    logic [31:0]            wb_cnt_q, wb_cnt_d;
    logic [31:0]            fill_cnt_q, fill_cnt_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d;

    logic                   seq_load, seq_advance, seq_last;
    logic [IW-1:0]          seq_start, seq_idx;
    logic [IW-1:0]          req_fill_start;
    logic                   active, accept, wb_active;
    logic [31:0]            beat_addr;
    logic [BEAT_BITS-1:0]   beat_wdata;

    beat_sequencer #(.BEATS(BEATS), .IW(IW)) u_seq (
        .clock     (clock),
        .reset     (reset),
        .load      (seq_load),
        .start_idx (seq_start),
        .advance   (seq_advance),
        .idx       (seq_idx),
        .last      (seq_last)
    );

    // Beat holding the requested word; only meaningful with several beats.
    always_comb begin
        req_fill_start = '0;
        if (CWF != 0 && BEATS > 1) req_fill_start = mem_addr[BEAT_SH +: IW];
    end

    // Gating with reset makes the RAM side go quiet in the reset cycle itself.
    assign active     = (state_q == WB || state_q == FILL) && !reset;
    assign wb_active  = active && (state_q == WB);
    assign accept     = active && !ram_miss;
    assign beat_addr  = ((state_q == WB) ? wb_base_q : fill_base_q)
                      + (32'(seq_idx) << BEAT_SH);
    assign beat_wdata = mem_write_block[int'(seq_idx) * BEAT_BITS +: BEAT_BITS];

    always_comb begin
        state_d      = state_q;
        wb_base_d    = wb_base_q;
        fill_base_d  = fill_base_q;
        fill_start_d = fill_start_q;
        rblock_d     = rblock_q;
        wb_cnt_d     = wb_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        seq_load     = 1'b0;
        seq_advance  = 1'b0;
        seq_start    = fill_start_q;
        addr_hold_d  = active    ? beat_addr  : addr_hold_q;
        wdata_hold_d = wb_active ? beat_wdata : wdata_hold_q;

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    wb_base_d    = mem_wb_addr & ~BLOCK_MASK;
                    fill_base_d  = mem_addr & ~BLOCK_MASK;
                    fill_start_d = req_fill_start;
                    seq_load     = 1'b1;
                    seq_start    = mem_we ? '0 : req_fill_start;
                    state_d      = mem_we ? WB : FILL;
                end
            end
            WB: begin
                if (accept) begin
                    if (!mem_req) begin
                        state_d = IDLE;
                    end else if (seq_last) begin
                        wb_cnt_d = wb_cnt_q + 32'd1;
                        seq_load = 1'b1;
                        state_d  = FILL;
                    end else begin
                        seq_advance = 1'b1;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    // partial data is kept even if the request is abandoned
                    rblock_d[int'(seq_idx) * BEAT_BITS +: BEAT_BITS] = ram_read_data;
                    if (!mem_req) begin
                        state_d = IDLE;
                    end else if (seq_last) begin
                        fill_cnt_d = fill_cnt_q + 32'd1;
                        state_d    = DONE;
                    end else begin
                        seq_advance = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (active && ram_miss) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wb_base_q    <= '0;
            fill_base_q  <= '0;
            fill_start_q <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            rblock_q     <= '0;
            wb_cnt_q     <= '0;
            fill_cnt_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wb_base_q    <= wb_base_d;
            fill_base_q  <= fill_base_d;
            fill_start_q <= fill_start_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
            rblock_q     <= rblock_d;
            wb_cnt_q     <= wb_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mem_miss       = mem_req && (state_q != DONE) && !reset;
    assign ram_req        = active;
    assign ram_we         = wb_active;
    assign ram_addr       = active    ? beat_addr  : addr_hold_q;
    assign ram_write_data = wb_active ? beat_wdata : wdata_hold_q;
    assign mem_read_block = rblock_q;
    assign wb_count       = wb_cnt_q;
    assign fill_count     = fill_cnt_q;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_cache_ram_burst_bridge.sv
// Bench for cache_ram_burst_bridge. Three instances share the request side:
//   a : BLOCKS=4, RAM_WORDS=1, CWF=0
//   b : BLOCKS=4, RAM_WORDS=1, CWF=1
//   c : BLOCKS=8, RAM_WORDS=2, CWF=0
// All three have four beats per block, so they run in lockstep. Each RAM
// returns a word derived from its byte address.
module tb_cache_ram_burst_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, mem_req, mem_we, ram_miss;
    logic [31:0]  mem_addr, mem_wb_addr;
    logic [127:0] wblk4;
    logic [255:0] wblk8;

    logic [127:0] a_rblk, b_rblk;
    logic [255:0] c_rblk;
    logic         a_mem_miss, b_mem_miss, c_mem_miss;
    logic         a_ram_req, b_ram_req, c_ram_req, a_ram_we, b_ram_we, c_ram_we;
    logic [31:0]  a_ram_addr, b_ram_addr, c_ram_addr;
    logic [31:0]  a_wd, b_wd, a_rd, b_rd;
    logic [63:0]  c_wd, c_rd;
    logic [31:0]  a_wbc, a_fc, a_sc, b_wbc, b_fc, b_sc, c_wbc, c_fc, c_sc;

    function automatic logic [31:0] rword(input logic [31:0] a);
        return 32'hCAFE_0000 | {16'h0000, a[15:0]};
    endfunction

    assign a_rd = rword(a_ram_addr);
    assign b_rd = rword(b_ram_addr);
    assign c_rd = {rword(c_ram_addr + 32'd4), rword(c_ram_addr)};

    cache_ram_burst_bridge #(.BLOCKS(4), .RAM_WORDS(1), .CWF(0)) dut_a (
        .clock(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wb_addr(mem_wb_addr), .mem_write_block(wblk4),
        .mem_read_block(a_rblk), .mem_miss(a_mem_miss), .ram_req(a_ram_req),
        .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_write_data(a_wd),
        .ram_read_data(a_rd), .ram_miss(ram_miss), .wb_count(a_wbc),
        .fill_count(a_fc), .stall_count(a_sc));

    cache_ram_burst_bridge #(.BLOCKS(4), .RAM_WORDS(1), .CWF(1)) dut_b (
        .clock(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wb_addr(mem_wb_addr), .mem_write_block(wblk4),
        .mem_read_block(b_rblk), .mem_miss(b_mem_miss), .ram_req(b_ram_req),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_write_data(b_wd),
        .ram_read_data(b_rd), .ram_miss(ram_miss), .wb_count(b_wbc),
        .fill_count(b_fc), .stall_count(b_sc));

    cache_ram_burst_bridge #(.BLOCKS(8), .RAM_WORDS(2), .CWF(0)) dut_c (
        .clock(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wb_addr(mem_wb_addr), .mem_write_block(wblk8),
        .mem_read_block(c_rblk), .mem_miss(c_mem_miss), .ram_req(c_ram_req),
        .ram_we(c_ram_we), .ram_addr(c_ram_addr), .ram_write_data(c_wd),
        .ram_read_data(c_rd), .ram_miss(ram_miss), .wb_count(c_wbc),
        .fill_count(c_fc), .stall_count(c_sc));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] a_aq[$];
    logic        a_wq[$];
    logic [31:0] a_dq[$];
    logic [31:0] b_aq[$];
    logic [31:0] c_aq[$];
    logic        c_wq[$];
    logic [63:0] c_dq[$];
    int a_mc, b_mc, c_mc, hold104;

    // One block transaction, logging accepted beats. Called on a negedge,
    // returns on the negedge of the IDLE cycle after DONE.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wb_addr, input int stall_beat,
                           input int stall_len);
        int beat;
        int left;
        bit done;
        a_aq.delete(); a_wq.delete(); a_dq.delete(); b_aq.delete();
        c_aq.delete(); c_wq.delete(); c_dq.delete();
        a_mc = 0; b_mc = 0; c_mc = 0; hold104 = 0;
        beat = 0; left = stall_len; done = 1'b0;
        mem_we = we; mem_addr = addr; mem_wb_addr = wb_addr; mem_req = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            ram_miss = (beat == stall_beat) && (left > 0);
            #1;
            if (!a_mem_miss && !b_mem_miss && !c_mem_miss) begin
                done = 1'b1;
            end else begin
                if (a_mem_miss) a_mc++;
                if (b_mem_miss) b_mc++;
                if (c_mem_miss) c_mc++;
                if (a_ram_req && a_ram_addr == 32'h104) hold104++;
                if (a_ram_req && !ram_miss) begin
                    a_aq.push_back(a_ram_addr); a_wq.push_back(a_ram_we); a_dq.push_back(a_wd);
                end
                if (b_ram_req && !ram_miss) b_aq.push_back(b_ram_addr);
                if (c_ram_req && !ram_miss) begin
                    c_aq.push_back(c_ram_addr); c_wq.push_back(c_ram_we); c_dq.push_back(c_wd);
                end
                if (a_ram_req) begin
                    if (ram_miss) left--;
                    else beat++;
                end
                @(negedge clk);
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL %s_timeout: mem_miss still high after 100 cycles, required low", tag); end
        mem_req = 1'b0; ram_miss = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (a_mem_miss !== 1'b0) begin n_bad++; $display("FAIL rst_mem_miss: got %b want 0", a_mem_miss); end
        n_cmp++; if (a_ram_req !== 1'b0 || a_ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_req_we: got %b%b want 00", a_ram_req, a_ram_we); end
        n_cmp++; if (a_ram_addr !== 32'h0 || a_wd !== 32'h0) begin n_bad++; $display("FAIL rst_ram_addr_data: got %h/%h want 0/0", a_ram_addr, a_wd); end
        n_cmp++; if (a_rblk !== 128'h0 || c_rblk !== 256'h0) begin n_bad++; $display("FAIL rst_read_block: got %h want 0", a_rblk); end
        n_cmp++; if (a_wbc !== 0 || a_fc !== 0 || a_sc !== 0) begin n_bad++; $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", a_wbc, a_fc, a_sc); end
        n_cmp++; if (c_wd !== 64'h0 || c_ram_addr !== 32'h0) begin n_bad++; $display("FAIL rst_c_ram: got %h/%h want 0/0", c_ram_addr, c_wd); end
        mem_req = 1'b0; reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 32'h100, 32'h0, -1, 0);
        n_cmp++; if (a_mc !== 5 || b_mc !== 5 || c_mc !== 5) begin n_bad++; $display("FAIL read_latency: got %0d/%0d/%0d want 5", a_mc, b_mc, c_mc); end
        n_cmp++; if (a_aq.size() !== 4 || c_aq.size() !== 4) begin n_bad++; $display("FAIL read_beats: got %0d/%0d want 4", a_aq.size(), c_aq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a_aq[i] !== 32'h100 + 32'(4*i) || a_wq[i] !== 1'b0) begin n_bad++; $display("FAIL read_a_addr%0d: got %h we %b want %h", i, a_aq[i], a_wq[i], 32'h100 + 32'(4*i)); end
            n_cmp++; if (b_aq[i] !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL read_b_addr%0d: got %h want %h", i, b_aq[i], 32'h100 + 32'(4*i)); end
            n_cmp++; if (c_aq[i] !== 32'h100 + 32'(8*i)) begin n_bad++; $display("FAIL read_c_addr%0d: got %h want %h", i, c_aq[i], 32'h100 + 32'(8*i)); end
            n_cmp++; if (a_rblk[32*i +: 32] !== rword(32'h100 + 32'(4*i))) begin n_bad++; $display("FAIL read_a_word%0d: got %h want %h", i, a_rblk[32*i +: 32], rword(32'h100 + 32'(4*i))); end
        end
        for (int j = 0; j < 8; j++) begin
            n_cmp++; if (c_rblk[32*j +: 32] !== rword(32'h100 + 32'(4*j))) begin n_bad++; $display("FAIL read_c_word%0d: got %h want %h", j, c_rblk[32*j +: 32], rword(32'h100 + 32'(4*j))); end
        end
        n_cmp++; if (a_fc !== 1 || c_fc !== 1 || a_wbc !== 0) begin n_bad++; $display("FAIL read_counts: fill %0d/%0d wb %0d want 1/1/0", a_fc, c_fc, a_wbc); end
        #1;
        n_cmp++; if (a_ram_req !== 1'b0 || a_ram_addr !== 32'h10C) begin n_bad++; $display("FAIL read_addr_hold: got req %b addr %h want 0 10c", a_ram_req, a_ram_addr); end
    endtask

    task automatic test_cwf();
        logic [31:0] exp_b [4];
        exp_b[0] = 32'h108; exp_b[1] = 32'h10C; exp_b[2] = 32'h100; exp_b[3] = 32'h104;
        @(negedge clk);
        run_txn("cwf", 1'b0, 32'h108, 32'h0, -1, 0);
        n_cmp++; if (b_aq.size() !== 4) begin n_bad++; $display("FAIL cwf_beats: got %0d want 4", b_aq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (b_aq[i] !== exp_b[i]) begin n_bad++; $display("FAIL cwf_b_addr%0d: got %h want %h", i, b_aq[i], exp_b[i]); end
            n_cmp++; if (a_aq[i] !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL cwf_a_addr%0d: got %h want %h", i, a_aq[i], 32'h100 + 32'(4*i)); end
            n_cmp++; if (b_rblk[32*i +: 32] !== rword(32'h100 + 32'(4*i))) begin n_bad++; $display("FAIL cwf_b_word%0d: got %h want %h", i, b_rblk[32*i +: 32], rword(32'h100 + 32'(4*i))); end
        end
        n_cmp++; if (b_rblk[64 +: 32] !== rword(32'h108)) begin n_bad++; $display("FAIL cwf_first_word: got %h want %h", b_rblk[64 +: 32], rword(32'h108)); end
        n_cmp++; if (b_mc !== 5 || b_fc !== 2) begin n_bad++; $display("FAIL cwf_latency_count: got %0d/%0d want 5/2", b_mc, b_fc); end
    endtask

    task automatic test_writeback();
        logic [63:0] exp_cd;
        wblk4 = {32'hA0A0_000D, 32'hA0A0_000C, 32'hA0A0_000B, 32'hA0A0_000A};
        for (int j = 0; j < 8; j++) wblk8[32*j +: 32] = 32'h5500_0000 + 32'(j);
        @(negedge clk);
        run_txn("wb", 1'b1, 32'h40, 32'h2008, -1, 0);
        n_cmp++; if (a_mc !== 9 || b_mc !== 9 || c_mc !== 9) begin n_bad++; $display("FAIL wb_latency: got %0d/%0d/%0d want 9", a_mc, b_mc, c_mc); end
        n_cmp++; if (a_aq.size() !== 8 || c_aq.size() !== 8) begin n_bad++; $display("FAIL wb_beats: got %0d/%0d want 8", a_aq.size(), c_aq.size()); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (a_aq[k] !== 32'h2000 + 32'(4*k) || a_wq[k] !== 1'b1 || a_dq[k] !== 32'hA0A0_000A + 32'(k)) begin n_bad++; $display("FAIL wb_a_beat%0d: got %h we %b data %h want %h 1 %h", k, a_aq[k], a_wq[k], a_dq[k], 32'h2000 + 32'(4*k), 32'hA0A0_000A + 32'(k)); end
            n_cmp++; if (a_aq[k+4] !== 32'h40 + 32'(4*k) || a_wq[k+4] !== 1'b0) begin n_bad++; $display("FAIL wb_a_fill%0d: got %h we %b want %h 0", k, a_aq[k+4], a_wq[k+4], 32'h40 + 32'(4*k)); end
            exp_cd = {32'h5500_0000 + 32'(2*k+1), 32'h5500_0000 + 32'(2*k)};
            n_cmp++; if (c_aq[k] !== 32'h2000 + 32'(8*k) || c_wq[k] !== 1'b1 || c_dq[k] !== exp_cd) begin n_bad++; $display("FAIL wb_c_beat%0d: got %h we %b data %h want %h 1 %h", k, c_aq[k], c_wq[k], c_dq[k], 32'h2000 + 32'(8*k), exp_cd); end
            n_cmp++; if (c_aq[k+4] !== 32'h40 + 32'(8*k) || c_wq[k+4] !== 1'b0) begin n_bad++; $display("FAIL wb_c_fill%0d: got %h we %b want %h 0", k, c_aq[k+4], c_wq[k+4], 32'h40 + 32'(8*k)); end
        end
        for (int j = 0; j < 8; j++) begin
            n_cmp++; if (c_rblk[32*j +: 32] !== rword(32'h40 + 32'(4*j))) begin n_bad++; $display("FAIL wb_c_word%0d: got %h want %h", j, c_rblk[32*j +: 32], rword(32'h40 + 32'(4*j))); end
        end
        n_cmp++; if (a_wbc !== 1 || b_wbc !== 1 || c_wbc !== 1 || a_fc !== 3) begin n_bad++; $display("FAIL wb_counts: wb %0d/%0d/%0d fill %0d want 1/1/1 3", a_wbc, b_wbc, c_wbc, a_fc); end
        #1;
        n_cmp++; if (a_wd !== 32'hA0A0_000D || a_ram_we !== 1'b0) begin n_bad++; $display("FAIL wb_data_hold: got %h we %b want a0a0000d 0", a_wd, a_ram_we); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        run_txn("stall", 1'b0, 32'h100, 32'h0, 1, 3);
        n_cmp++; if (a_mc !== 8 || c_mc !== 8) begin n_bad++; $display("FAIL stall_latency: got %0d/%0d want 8", a_mc, c_mc); end
        n_cmp++; if (hold104 !== 4) begin n_bad++; $display("FAIL stall_addr_stable: got %0d cycles want 4", hold104); end
        n_cmp++; if (a_sc !== 3 || c_sc !== 3) begin n_bad++; $display("FAIL stall_count: got %0d/%0d want 3", a_sc, c_sc); end
        n_cmp++; if (a_fc !== 4) begin n_bad++; $display("FAIL stall_fill_count: got %0d want 4", a_fc); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a_aq[i] !== 32'h100 + 32'(4*i)) begin n_bad++; $display("FAIL stall_addr%0d: got %h want %h", i, a_aq[i], 32'h100 + 32'(4*i)); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        @(negedge clk);
        mem_addr = 32'h100; mem_we = 1'b0; mem_req = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (a_ram_req && a_ram_addr == 32'h108) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_reach_beat2: beat 0x108 not presented within 20 cycles"); end
        reset = 1'b1;
        #1;
        n_cmp++; if (a_mem_miss !== 1'b0) begin n_bad++; $display("FAIL rstmid_miss_forced: got %b want 0", a_mem_miss); end
        @(negedge clk);
        #1;
        n_cmp++; if (a_ram_req !== 1'b0 || c_ram_req !== 1'b0 || a_mem_miss !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: req %b/%b miss %b want 0/0/0", a_ram_req, c_ram_req, a_mem_miss); end
        n_cmp++; if (a_fc !== 0 || a_sc !== 0 || a_wbc !== 0) begin n_bad++; $display("FAIL rstmid_counters: got %0d/%0d/%0d want 0/0/0", a_fc, a_sc, a_wbc); end
        n_cmp++; if (a_rblk !== 128'h0) begin n_bad++; $display("FAIL rstmid_block: got %h want 0", a_rblk); end
        mem_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        run_txn("after_rst", 1'b0, 32'h100, 32'h0, -1, 0);
        n_cmp++; if (a_mc !== 5 || a_fc !== 1 || a_wbc !== 0 || b_fc !== 1) begin n_bad++; $display("FAIL after_rst_txn: lat %0d fill %0d wb %0d bfill %0d want 5 1 0 1", a_mc, a_fc, a_wbc, b_fc); end
        n_cmp++; if (a_aq.size() !== 4 || a_aq[0] !== 32'h100) begin n_bad++; $display("FAIL after_rst_first: size %0d first %h want 4 100", a_aq.size(), a_aq[0]); end
        n_cmp++; if (a_rblk[64 +: 32] !== rword(32'h108)) begin n_bad++; $display("FAIL after_rst_word2: got %h want %h", a_rblk[64 +: 32], rword(32'h108)); end
    endtask

    task automatic test_drop();
        @(negedge clk);
        mem_addr = 32'h200; mem_we = 1'b0; mem_req = 1'b1; ram_miss = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ram_miss = 1'b1; mem_req = 1'b0;
        #1;
        n_cmp++; if (a_ram_req !== 1'b1 || a_ram_addr !== 32'h204 || a_mem_miss !== 1'b0) begin n_bad++; $display("FAIL drop_inflight: req %b addr %h miss %b want 1 204 0", a_ram_req, a_ram_addr, a_mem_miss); end
        @(negedge clk);
        @(negedge clk);
        ram_miss = 1'b0;
        #1;
        n_cmp++; if (a_ram_req !== 1'b1 || a_ram_addr !== 32'h204) begin n_bad++; $display("FAIL drop_wait_accept: req %b addr %h want 1 204", a_ram_req, a_ram_addr); end
        @(negedge clk);
        #1;
        n_cmp++; if (a_ram_req !== 1'b0 || a_fc !== 1 || a_sc !== 2) begin n_bad++; $display("FAIL drop_idle: req %b fill %0d stall %0d want 0 1 2", a_ram_req, a_fc, a_sc); end
        n_cmp++; if (a_rblk !== {rword(32'h10C), rword(32'h108), rword(32'h204), rword(32'h200)}) begin n_bad++; $display("FAIL drop_partial_block: got %h", a_rblk); end
    endtask

    initial begin
        reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; ram_miss = 1'b0;
        mem_addr = '0; mem_wb_addr = '0; wblk4 = '0; wblk8 = '0;
        @(negedge clk);
        test_reset();
        test_read();
        test_cwf();
        test_writeback();
        test_stall();
        test_reset_mid();
        test_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
